pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Multicycle fetch/advance sequencer for the accumulator processor.
- Sits downstream of the skip-decision logic and consumes its `skip` flag.
- Owns the program counter, fetches each instruction over a req/ready handshake, hands it to execute, then advances the PC.
- PC advance is +1 normally, +2 when the completed instruction resolved a skip, or a load of a jump target.

Parameters:
- PC_W, 16, program counter / instruction-address width in bits
- INSTR_W, 16, instruction word width in bits
- RESET_PC, 0, PC value loaded on reset

Ports:
- CLK  input  1  system clock; all state updates on the rising edge
- Reset  input  1  synchronous, active-high reset
- imem_req  output  1  fetch request, held high until imem_ready
- imem_addr  output  PC_W  fetch address; always equals pc while imem_req=1
- imem_ready  input  1  fetch data valid this cycle; ignored unless imem_req=1
- imem_rdata  input  INSTR_W  instruction word from memory
- instr  output  INSTR_W  latched current instruction (opcode [15:12], funct [3:0] feed the skip logic)
- instr_valid  output  1  one-cycle pulse: instr is new and execute may begin
- exec_done  input  1  execute stage has completed the current instruction; skip/jump are valid this cycle
- skip  input  1  skip decision for the current instruction (from skip logic)
- jump  input  1  current instruction redirects the PC
- jump_target  input  PC_W  redirect address, valid with jump
- halt  input  1  current instruction is HALT
- pc  output  PC_W  address of the current instruction
- skipped  output  1  one-cycle pulse when a skip was taken
- halted  output  1  high while in HALT state

Behaviour:
- Reset values (Reset=1 at an edge, any state):
  - state=FETCH, pc=RESET_PC, instr=0
  - imem_req=0, instr_valid=0, skipped=0, halted=0
  - Reset overrides all other inputs, including mid-fetch and mid-execute; any pending imem_ready is discarded.
- States: FETCH, DECODE, EXEC, HALT (2-bit encoding).
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ready=1: instr<=imem_rdata, go to DECODE.
  - Otherwise stay in FETCH; wait is unbounded.
  - imem_req is registered and rises the cycle after entering FETCH. It deasserts the cycle after ready is sampled.
- DECODE:
  - One cycle; instr_valid=1 for exactly this cycle.
  - Next state is EXEC.
- EXEC:
  - Wait for exec_done; exec_done outside EXEC is ignored.
  - When exec_done=1, resolve with priority halt > jump > skip > sequential:
    - halt: pc unchanged, go to HALT, halted<=1.
    - jump: pc<=jump_target, go to FETCH. skip is ignored, skipped stays 0.
    - skip: pc<=pc+2, skipped pulses 1 for one cycle, go to FETCH.
    - else: pc<=pc+1, go to FETCH.
- Arithmetic:
  - pc increments are modulo 2^PC_W.
  - pc=2^PC_W-1 advances to 0 (+1) or to 1 (+2).
  - pc=2^PC_W-2 with skip wraps to 0.
- HALT:
  - Absorbing state; only Reset leaves it.
  - imem_req=0, all pulses 0.
- Latency:
  - Minimum instruction period is 4 cycles: FETCH request cycle, ready cycle, DECODE, EXEC with exec_done=1.
  - This assumes imem_ready returns in the first request cycle.
- instr and pc are stable from DECODE through the exec_done cycle; pc updates on the edge ending that cycle.
- imem_rdata is sampled only in the ready cycle; later changes do not affect instr.

Test Plan:
1. Reset with RESET_PC=0; imem returns 0x1000 with ready after 1 cycle, exec_done after 2 cycles -> one instr_valid pulse with instr=0x1000; pc 0->1; next imem_addr=1.
2. Sequential run of 3 instructions with skip=0 -> fetch addresses 0,1,2; pc ends at 3; skipped never asserts.
3. At pc=5, exec_done with skip=1 -> pc=7, skipped pulses exactly once, next imem_addr=7; address 6 is never requested.
4. At pc=5, exec_done with jump=1, jump_target=0x0040, skip=1 -> pc=0x0040, skipped=0.
5. Wrap: pc=0xFFFF with skip -> pc=0x0001; pc=0xFFFF without skip -> pc=0x0000.
6. Hold imem_ready=0 for 10 cycles -> imem_req stays 1 and imem_addr stays stable. Then:
   - Assert Reset mid-EXEC -> state FETCH, pc=0, outputs at reset values.
   - Assert halt with exec_done -> halted=1, imem_req stays 0 until Reset.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle fetch/advance sequencer for the accumulator core.
// Owns the program counter, fetches one instruction over a req/ready
// handshake, presents it to execute for one DECODE cycle, then advances the
// PC by +1, +2 (skip taken) or loads a jump target once execute completes.
module pc_sequencer #(
    parameter int PC_W     = 16,
    parameter int INSTR_W  = 16,
    parameter int RESET_PC = 0
) (
    input  logic               CLK,
    input  logic               Reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               exec_done,
    input  logic               skip,
    input  logic               jump,
    input  logic [PC_W-1:0]    jump_target,
    input  logic               halt,
    output logic [PC_W-1:0]    pc,
    output logic               skipped,
    output logic               halted
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               req_q, req_d;
    logic               skipped_q, skipped_d;

    // State register: all sequencer state, reset overrides everything
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= S_FETCH;
            pc_q      <= PC_W'(RESET_PC);
            instr_q   <= '0;
            req_q     <= 1'b0;
            skipped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            req_q     <= req_d;
            skipped_q <= skipped_d;
        end
    end

    // Next-state logic: handshake, decode hand-off and PC resolution
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        req_d     = 1'b0;
        skipped_d = 1'b0;
        case (state_q)
            S_FETCH: begin
                // Request is registered, so it rises one cycle after entry;
                // ready only counts while the request is actually visible.
                req_d = 1'b1;
                if (req_q && imem_ready) begin
                    instr_d = imem_rdata;
                    req_d   = 1'b0;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // Priority: halt > jump > skip > sequential
                if (exec_done) begin
                    if (halt) begin
                        state_d = S_HALT;
                    end else if (jump) begin
                        pc_d    = jump_target;
                        state_d = S_FETCH;
                    end else if (skip) begin
                        pc_d      = pc_q + PC_W'(2);
                        skipped_d = 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        pc_d    = pc_q + PC_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Output logic: registered handshake/pulses plus state-decoded flags
    always_comb begin
        imem_req    = req_q;
        imem_addr   = pc_q;
        instr       = instr_q;
        pc          = pc_q;
        skipped     = skipped_q;
        instr_valid = (state_q == S_DECODE);
        halted      = (state_q == S_HALT);
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic        skip;
    logic        jump;
    logic [15:0] jump_target;
    logic        halt;
    logic [15:0] pc;
    logic        skipped;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;
    int skip_cnt = 0;

    pc_sequencer #(.PC_W(16), .INSTR_W(16), .RESET_PC(0)) dut (
        .CLK(CLK), .Reset(Reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .exec_done(exec_done), .skip(skip), .jump(jump),
        .jump_target(jump_target), .halt(halt),
        .pc(pc), .skipped(skipped), .halted(halted)
    );

    always #5 CLK = ~CLK;

    // Count every cycle the skipped pulse is high
    always @(negedge CLK) if (skipped === 1'b1) skip_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        imem_ready  = 1'b0;
        imem_rdata  = 16'h0;
        exec_done   = 1'b0;
        skip        = 1'b0;
        jump        = 1'b0;
        jump_target = 16'h0;
        halt        = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    // Wait for the request, optionally stall 'hold' cycles, then return 'word'
    task automatic fetch(input logic [15:0] exp_addr, input logic [15:0] word, input int hold);
        int w;
        w = 0;
        while (imem_req !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk("req_rise", imem_req, 1);
        chk("fetch_addr", imem_addr, exp_addr);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("stall_req", imem_req, 1);
            chk("stall_addr", imem_addr, exp_addr);
        end
        imem_rdata = word;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        imem_rdata = 16'hDEAD;
        chk("instr_valid", instr_valid, 1);
        chk("instr", instr, word);
        chk("req_drop", imem_req, 0);
        tick();
        chk("valid_pulse", instr_valid, 0);
        chk("instr_hold", instr, word);
    endtask

    task automatic execute(input logic s, input logic j, input logic [15:0] tgt, input logic h);
        exec_done   = 1'b1;
        skip        = s;
        jump        = j;
        jump_target = tgt;
        halt        = h;
        tick();
        clear_inputs();
    endtask

    initial begin
        int sc;
        Reset = 1'b0;
        clear_inputs();

        // 1: reset values, single instruction, pc 0 -> 1
        do_reset();
        chk("rst_req", imem_req, 0);
        chk("rst_pc", pc, 0);
        chk("rst_instr", instr, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_skipped", skipped, 0);
        chk("rst_halted", halted, 0);
        fetch(16'h0000, 16'h1000, 0);
        tick();
        chk("exec_wait_pc", pc, 0);
        execute(0, 0, 16'h0, 0);
        chk("t1_pc", pc, 1);
        chk("t1_next_addr", imem_addr, 1);

        // 2: three sequential instructions from 0
        do_reset();
        for (int i = 0; i < 3; i++) begin
            fetch(16'(i), 16'(16'h2000 + i), 0);
            execute(0, 0, 16'h0, 0);
        end
        chk("t2_pc", pc, 3);
        chk("t2_no_skip", skip_cnt, 0);

        // 3: skip at pc=5 -> 7
        fetch(16'h0003, 16'h3000, 0);
        execute(0, 1, 16'h0005, 0);
        chk("t3_jump_pc", pc, 5);
        fetch(16'h0005, 16'h3001, 0);
        execute(1, 0, 16'h0, 0);
        chk("t3_pc", pc, 7);
        chk("t3_skipped", skipped, 1);
        tick();
        chk("t3_skipped_pulse", skipped, 0);
        chk("t3_skip_cnt", skip_cnt, 1);
        fetch(16'h0007, 16'h3002, 0);

        // 4: jump wins over skip
        execute(0, 1, 16'h0005, 0);
        fetch(16'h0005, 16'h4000, 0);
        sc = skip_cnt;
        execute(1, 1, 16'h0040, 0);
        chk("t4_pc", pc, 16'h0040);
        chk("t4_skipped", skipped, 0);
        tick();
        chk("t4_skip_cnt", skip_cnt, sc);

        // 5: wrap-around
        fetch(16'h0040, 16'h5000, 0);
        execute(0, 1, 16'hFFFF, 0);
        fetch(16'hFFFF, 16'h5001, 0);
        execute(1, 0, 16'h0, 0);
        chk("t5_wrap_skip", pc, 16'h0001);
        fetch(16'h0001, 16'h5002, 0);
        execute(0, 1, 16'hFFFF, 0);
        fetch(16'hFFFF, 16'h5003, 0);
        execute(0, 0, 16'h0, 0);
        chk("t5_wrap_seq", pc, 16'h0000);
        fetch(16'h0000, 16'h5004, 0);
        execute(0, 1, 16'hFFFE, 0);
        fetch(16'hFFFE, 16'h5005, 0);
        execute(1, 0, 16'h0, 0);
        chk("t5_wrap_fffe", pc, 16'h0000);

        // 6: long stall, reset mid-EXEC, then halt
        fetch(16'h0000, 16'h0000, 0);
        execute(0, 1, 16'h1234, 0);
        fetch(16'h1234, 16'h6000, 10);
        exec_done  = 1'b1;
        imem_ready = 1'b1;
        Reset      = 1'b1;
        tick();
        Reset = 1'b0;
        clear_inputs();
        chk("t6_rst_pc", pc, 0);
        chk("t6_rst_req", imem_req, 0);
        chk("t6_rst_instr", instr, 0);
        chk("t6_rst_valid", instr_valid, 0);
        chk("t6_rst_skipped", skipped, 0);
        chk("t6_rst_halted", halted, 0);
        fetch(16'h0000, 16'h7000, 0);
        execute(1, 1, 16'h0099, 1);
        chk("t6_halted", halted, 1);
        chk("t6_halt_pc", pc, 0);
        for (int i = 0; i < 5; i++) begin
            imem_ready = 1'b1;
            exec_done  = 1'b1;
            tick();
            chk("t6_halt_req", imem_req, 0);
            chk("t6_halt_stay", halted, 1);
            chk("t6_halt_valid", instr_valid, 0);
        end
        clear_inputs();
        do_reset();
        chk("t6_unhalt", halted, 0);
        chk("t6_unhalt_pc", pc, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
